// File: rtl/mult_div_unit_if.sv
// Handshake and operand bundle between control/regfile and the HI/LO unit.
// master drives operands and commands; slave returns HI/LO and status.
interface mult_div_unit_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        HiWrite;
    logic        LoWrite;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    modport master (
        output Start, Op, OperandA, OperandB, HiWrite, LoWrite,
        input  Hi, Lo, Busy, Done
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, HiWrite, LoWrite,
        output Hi, Lo, Busy, Done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine holding the MIPS HI/LO registers.
// One bit per cycle on operand magnitudes, sign fixed up in FINISH.
module mult_div_unit (
    input  logic         clk,
    input  logic         rst_n,
    mult_div_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        in_sgn;
    logic        in_neg_a;
    logic        in_neg_b;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_tmp;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_step;

    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;
    logic [31:0] a_raw;

    // Operand capture: signed ops work on two's-complement magnitudes.
    always_comb begin
        in_sgn   = ~bus.Op[0];
        in_neg_a = in_sgn & bus.OperandA[31];
        in_neg_b = in_sgn & bus.OperandB[31];
        in_mag_a = in_neg_a ? (32'd0 - bus.OperandA) : bus.OperandA;
        in_mag_b = in_neg_b ? (32'd0 - bus.OperandB) : bus.OperandB;
    end

    // One shift-add or restoring-subtract step on the shared accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
        mul_step = {mul_sum, acc[31:1]};
        div_tmp  = acc[63:31];
        div_ge   = div_tmp >= {1'b0, mag_b};
        div_rem  = div_tmp[31:0] - mag_b;
        div_step = div_ge ? {div_rem, acc[30:0], 1'b1}
                          : {div_tmp[31:0], acc[30:0], 1'b0};
    end

    // Sign correction of the magnitude results.
    always_comb begin
        mul_res = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
        quo_res = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_res = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
        a_raw   = neg_a ? (32'd0 - mag_a) : mag_a;
    end

    // Next-state: 32 RUN iterations, then one FINISH cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.Start) state_nx = RUN;
            RUN:     if (cnt == 6'd31) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand latch, iteration counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 6'd0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
        end else if (state == IDLE) begin
            if (bus.Start) begin
                cnt    <= 6'd0;
                is_div <= bus.Op[1];
                neg_a  <= in_neg_a;
                neg_b  <= in_neg_b;
                mag_a  <= in_mag_a;
                mag_b  <= in_mag_b;
                acc    <= {32'd0, (bus.Op[1] ? in_mag_a : in_mag_b)};
            end
        end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
            acc <= is_div ? div_step : mul_step;
        end
    end

    // HI/LO: MTHI/MTLO in IDLE (Start has priority), results in FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FINISH);
            if (state == IDLE && !bus.Start) begin
                if (bus.HiWrite) hi_q <= bus.OperandA;
                if (bus.LoWrite) lo_q <= bus.OperandA;
            end else if (state == FINISH) begin
                if (!is_div) begin
                    hi_q <= mul_res[63:32];
                    lo_q <= mul_res[31:0];
                end else if (mag_b == 32'd0) begin
                    hi_q <= a_raw;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= rem_res;
                    lo_q <= quo_res;
                end
            end
        end
    end

    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed test-plan cases,
// random ops against an arithmetic model, handshake and reset corners.
module tb_mult_div_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain arithmetic on the ISA rules.
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = 64'(sa * sb);
                return p;
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drive Start for one edge (E0); return at E0+1 with operands scrambled.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.Start    = 1'b1;
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        @(posedge clk);
        #1;
        bus.Start    = 1'b0;
        bus.Op       = 2'($urandom);
        bus.OperandA = $urandom;
        bus.OperandB = $urandom;
    endtask

    // From E0+1: measure latency, busy cycles, mid-run HI/LO, Done after.
    task automatic wait_done(output int lat, output int busy_cnt,
                             output logic [31:0] hi_mid,
                             output logic [31:0] lo_mid,
                             output logic done_after);
        lat      = 0;
        busy_cnt = bus.Busy ? 1 : 0;
        hi_mid   = bus.Hi;
        lo_mid   = bus.Lo;
        while (!bus.Done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.Busy) busy_cnt++;
            if (lat == 16) begin
                hi_mid = bus.Hi;
                lo_mid = bus.Lo;
            end
        end
        @(posedge clk);
        #1;
        done_after = bus.Done;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.Op       = 2'd0;
        bus.OperandA = 32'd0;
        bus.OperandB = 32'd0;
        bus.HiWrite  = 1'b0;
        bus.LoWrite  = 1'b0;
        #2;
        checks++;
        if ({bus.Hi, bus.Lo, bus.Busy, bus.Done} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state got %h/%h busy=%b done=%b want 0",
                     bus.Hi, bus.Lo, bus.Busy, bus.Done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Run one op end-to-end and check result, latency and handshake.
    task automatic run_checked(input string name, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
        int          lat;
        int          bc;
        logic [31:0] hm;
        logic [31:0] lm;
        logic        da;
        logic [31:0] hi0;
        logic [31:0] lo0;
        logic [63:0] exp;
        exp = model(op, a, b);
        hi0 = bus.Hi;
        lo0 = bus.Lo;
        issue(op, a, b);
        wait_done(lat, bc, hm, lm, da);
        checks++;
        if ({bus.Hi, bus.Lo} !== exp) begin
            errors++;
            $display("FAIL %s result got %h_%h want %h", name,
                     bus.Hi, bus.Lo, exp);
        end
        checks++;
        if (lat !== 33 || bc !== 33 || da !== 1'b0) begin
            errors++;
            $display("FAIL %s timing got lat=%0d busy=%0d done2=%b want 33 33 0",
                     name, lat, bc, da);
        end
        checks++;
        if (hm !== hi0 || lm !== lo0) begin
            errors++;
            $display("FAIL %s hold got %h_%h want %h_%h", name, hm, lm,
                     hi0, lo0);
        end
    endtask

    task automatic test_directed();
        run_checked("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_checked("mult_neg", 2'd0, 32'hFFFF_FFFB, 32'd3);
        run_checked("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_checked("divu_5_3", 2'd3, 32'd5, 32'd3);
        run_checked("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_checked("divu_zero", 2'd3, 32'd9, 32'd0);
        run_checked("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0);
        run_checked("div_rem_neg", 2'd2, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (i % 5 == 1) b = b >> $urandom_range(31, 8);
            if (i % 7 == 3) b = 32'd0;
            run_checked("random", op, a, b);
        end
    endtask

    task automatic test_ignore_busy();
        int          lat;
        int          bc;
        logic [31:0] hm;
        logic [31:0] lm;
        logic        da;
        logic [63:0] exp;
        exp = model(2'd1, 32'h0001_0003, 32'h0000_0007);
        issue(2'd1, 32'h0001_0003, 32'h0000_0007);
        repeat (4) @(posedge clk);
        #1;
        bus.Start    = 1'b1;
        bus.Op       = 2'd2;
        bus.OperandA = 32'h1234;
        bus.OperandB = 32'd5;
        bus.HiWrite  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start   = 1'b0;
        bus.HiWrite = 1'b0;
        wait_done(lat, bc, hm, lm, da);
        checks++;
        if ({bus.Hi, bus.Lo} !== exp || lat !== 28) begin
            errors++;
            $display("FAIL busy_ignore got %h_%h lat=%0d want %h lat=28",
                     bus.Hi, bus.Lo, lat, exp);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL no_second_op got busy=%b done=%b want 0 0",
                     bus.Busy, bus.Done);
        end
    endtask

    task automatic test_mt_writes();
        logic [31:0] lo0;
        lo0          = bus.Lo;
        bus.HiWrite  = 1'b1;
        bus.OperandA = 32'h1234;
        @(posedge clk);
        #1;
        bus.HiWrite = 1'b0;
        checks++;
        if (bus.Hi !== 32'h1234 || bus.Lo !== lo0) begin
            errors++;
            $display("FAIL mthi got %h_%h want 00001234_%h", bus.Hi,
                     bus.Lo, lo0);
        end
        bus.HiWrite  = 1'b1;
        bus.LoWrite  = 1'b1;
        bus.OperandA = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        checks++;
        if (bus.Hi !== 32'hCAFE_F00D || bus.Lo !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL mt_both got %h_%h want cafef00d_cafef00d",
                     bus.Hi, bus.Lo);
        end
    endtask

    task automatic test_start_with_write();
        int          lat;
        int          bc;
        logic [31:0] hm;
        logic [31:0] lm;
        logic        da;
        bus.LoWrite = 1'b1;
        issue(2'd3, 32'd100, 32'd7);
        bus.LoWrite = 1'b0;
        checks++;
        if (bus.Lo !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL start_drops_mtlo got %h want cafef00d", bus.Lo);
        end
        wait_done(lat, bc, hm, lm, da);
        checks++;
        if (bus.Lo !== 32'd14 || bus.Hi !== 32'd2) begin
            errors++;
            $display("FAIL start_with_mtlo got %h_%h want 00000002_0000000e",
                     bus.Hi, bus.Lo);
        end
    endtask

    task automatic test_async_reset();
        bus.HiWrite  = 1'b1;
        bus.LoWrite  = 1'b1;
        bus.OperandA = 32'h0000_AAAA;
        @(posedge clk);
        #1;
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        issue(2'd0, 32'h7654_3210, 32'h0123_4567);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Hi, bus.Lo, bus.Busy, bus.Done} !== 66'd0) begin
            errors++;
            $display("FAIL async_reset got %h_%h busy=%b done=%b want 0",
                     bus.Hi, bus.Lo, bus.Busy, bus.Done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_checked("after_reset", 2'd1, 32'd5, 32'd3);
        checks++;
        if (bus.Lo !== 32'd15 || bus.Hi !== 32'd0) begin
            errors++;
            $display("FAIL after_reset_val got %h_%h want 0_f", bus.Hi,
                     bus.Lo);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          bc;
        logic [31:0] hm;
        logic [31:0] lm;
        logic        da;
        logic [63:0] e1;
        logic [63:0] e2;
        e1 = model(2'd2, 32'hFFFF_F000, 32'd77);
        e2 = model(2'd0, 32'h8000_0000, 32'h8000_0000);
        issue(2'd2, 32'hFFFF_F000, 32'd77);
        lat = 0;
        while (!bus.Done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if ({bus.Hi, bus.Lo} !== e1 || lat !== 33) begin
            errors++;
            $display("FAIL b2b_first got %h_%h lat=%0d want %h lat=33",
                     bus.Hi, bus.Lo, lat, e1);
        end
        issue(2'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bc, hm, lm, da);
        checks++;
        if ({bus.Hi, bus.Lo} !== e2 || lat !== 33 || bc !== 33) begin
            errors++;
            $display("FAIL b2b_second got %h_%h lat=%0d busy=%0d want %h 33 33",
                     bus.Hi, bus.Lo, lat, bc, e2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_mt_writes();
        test_start_with_write();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
